// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register file read side and the muldiv unit.
interface muldiv_unit_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, rs1_data, rs2_data, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and result select in a final cycle.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;
  logic [CW-1:0]     count_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              fast_q;
  logic [XLEN-1:0]   fast_res_q;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  // Accept-time decode: operand magnitudes, sign flags and the no-iteration cases.
  logic            a_signed;
  logic            b_signed;
  logic            neg_a;
  logic            neg_b;
  logic            div0;
  logic            ovf;
  logic            fast_d;
  logic [XLEN-1:0] a_abs_d;
  logic [XLEN-1:0] b_abs_d;
  logic [XLEN-1:0] fast_res_d;

  always_comb begin
    a_signed   = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                 (bus.op == OP_DIV)  || (bus.op == OP_REM);
    b_signed   = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    neg_a      = a_signed && bus.rs1_data[XLEN-1];
    neg_b      = b_signed && bus.rs2_data[XLEN-1];
    a_abs_d    = cond_neg(bus.rs1_data, neg_a);
    b_abs_d    = cond_neg(bus.rs2_data, neg_b);
    div0       = bus.op[2] && (bus.rs2_data == '0);
    ovf        = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                 (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);
    fast_d     = div0 || ovf;
    fast_res_d = '0;
    if (div0) begin
      fast_res_d = bus.op[1] ? bus.rs1_data : '1;
    end else if (ovf) begin
      fast_res_d = bus.op[1] ? '0 : bus.rs1_data;
    end
  end

  // One radix-2 step for each kind, plus the fix-up/select of the final cycle.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem_ext;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_acc_d;
  logic [2*XLEN-1:0] div_acc_d;
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   quo_d;
  logic [XLEN-1:0]   rem_d;
  logic [XLEN-1:0]   result_d;

  always_comb begin
    mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_acc_d   = {mul_sum, acc_q[XLEN-1:1]};
    div_rem_ext = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff    = div_rem_ext - {1'b0, b_q};
    div_ge      = ~div_diff[XLEN];
    div_acc_d   = {(div_ge ? div_diff[XLEN-1:0] : div_rem_ext[XLEN-1:0]),
                   acc_q[XLEN-2:0], div_ge};
    prod_d      = cond_neg2(acc_q, neg_res_q);
    quo_d       = cond_neg(acc_q[XLEN-1:0], neg_res_q);
    rem_d       = cond_neg(acc_q[2*XLEN-1:XLEN], neg_rem_q);
    unique case (op_q)
      OP_MUL:                       result_d = prod_d[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_d[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result_d = quo_d;
      default:                      result_d = rem_d;
    endcase
    if (fast_q) begin
      result_d = fast_res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              op_q       <= bus.op;
              rd_q       <= bus.rd_in;
              a_q        <= a_abs_d;
              b_q        <= b_abs_d;
              // Multiply iterates over the multiplier bits, divide over the dividend bits.
              acc_q      <= {{XLEN{1'b0}}, (bus.op[2] ? a_abs_d : b_abs_d)};
              neg_res_q  <= neg_a ^ neg_b;
              neg_rem_q  <= neg_a;
              fast_q     <= fast_d;
              fast_res_q <= fast_res_d;
              count_q    <= fast_d ? '0 : CW'(XLEN);
              state_q    <= fast_d ? S_FIX : S_CALC;
              busy_q     <= 1'b1;
            end
          end
          S_CALC: begin
            acc_q   <= op_q[2] ? div_acc_d : mul_acc_d;
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_q <= S_FIX;
            end
          end
          S_FIX: begin
            result_q <= result_d;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule
